// File: rtl/conv_layer_ctrl_if.sv
// Host and engine-side signal bundle for conv_layer_ctrl.
// The master modport is the controller's view; slave is the host/engine side.
interface conv_layer_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  start;
  logic                  abort;
  logic [3:0]            num_layers;
  logic                  i2c_done;
  logic                  gemm_done;
  logic                  i2c_rst_n;
  logic [ADDR_WIDTH-1:0] i2c_img_base;
  logic                  gemm_rst_n;
  logic [ADDR_WIDTH-1:0] gemm_out_base;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [3:0]            cur_layer;

  modport master (
    input  start, abort, num_layers,
    input  i2c_done, gemm_done,
    output i2c_rst_n, i2c_img_base,
    output gemm_rst_n, gemm_out_base,
    output busy, done, error, cur_layer
  );

  modport slave (
    output start, abort, num_layers,
    output i2c_done, gemm_done,
    input  i2c_rst_n, i2c_img_base,
    input  gemm_rst_n, gemm_out_base,
    input  busy, done, error, cur_layer
  );
endinterface

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer: restarts im2col then GEMM once per layer,
// ping-ponging activations between two buffers, with a per-phase watchdog.
module conv_layer_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [15:0] BUF_A      = 16'h0000,
  parameter logic [15:0] BUF_B      = 16'h4000,
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 4096
) (
  input logic               clk,
  input logic               rst_n,
  conv_layer_ctrl_if.master bus
);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam int RCW = $clog2(RST_CYCLES) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADR_A = ADDR_WIDTH'(BUF_A);
  localparam logic [ADDR_WIDTH-1:0] ADR_B = ADDR_WIDTH'(BUF_B);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, I2C_RST, I2C_WAIT, GEMM_RST, GEMM_WAIT, ERR
  } state_t;

  state_t                state_q, state_d;
  logic [RCW-1:0]        rcnt_q, rcnt_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  arm_q, arm_d;
  logic [3:0]            nl_q, nl_d;
  logic [3:0]            cur_q, cur_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  i2c_rn_q, i2c_rn_d;
  logic                  gemm_rn_q, gemm_rn_d;
  logic [ADDR_WIDTH-1:0] img_q, img_d;
  logic [ADDR_WIDTH-1:0] out_q, out_d;

  logic legal, wait_st, eng_done, cmpl, tmo, last;

  always_comb begin
    legal    = (bus.num_layers != 4'd0) &&
               (32'(bus.num_layers) <= MAX_LAYERS);
    wait_st  = (state_q == I2C_WAIT) || (state_q == GEMM_WAIT);
    eng_done = (state_q == I2C_WAIT) ? bus.i2c_done : bus.gemm_done;
    cmpl     = arm_q && eng_done;
    tmo      = (wd_q == WD_LAST);
    last     = (cur_q == nl_q - 4'd1);

    state_d = state_q;
    rcnt_d  = rcnt_q;
    wd_d    = wd_q;
    arm_d   = arm_q;
    nl_d    = nl_q;
    cur_d   = cur_q;
    done_d  = done_q;
    err_d   = err_q;

    // Arm only after the engine shows done=0, so a stale level is ignored
    if (wait_st) begin
      wd_d = wd_q + WDW'(1);
      if (!eng_done) arm_d = 1'b1;
    end

    unique case (state_q)
      IDLE, ERR: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end else if (bus.start) begin
          done_d = 1'b0;
          if (legal) begin
            state_d = I2C_RST;
            nl_d    = bus.num_layers;
            cur_d   = 4'd0;
            err_d   = 1'b0;
            rcnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      I2C_RST, GEMM_RST: begin
        if (rcnt_q == RC_LAST) begin
          state_d = (state_q == I2C_RST) ? I2C_WAIT : GEMM_WAIT;
          wd_d    = '0;
          arm_d   = 1'b0;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      I2C_WAIT: begin
        if (cmpl) begin
          state_d = GEMM_RST;
          rcnt_d  = '0;
        end else if (tmo) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      GEMM_WAIT: begin
        if (cmpl) begin
          rcnt_d = '0;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = I2C_RST;
            cur_d   = cur_q + 4'd1;
          end
        end else if (tmo) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy_q && bus.abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // Engine resets, busy and bases all follow the next state directly
    i2c_rn_d  = (state_d == I2C_WAIT);
    gemm_rn_d = (state_d == GEMM_WAIT);
    busy_d    = (state_d == I2C_RST) || (state_d == I2C_WAIT) ||
                (state_d == GEMM_RST) || (state_d == GEMM_WAIT);
    img_d     = cur_d[0] ? ADR_B : ADR_A;
    out_d     = cur_d[0] ? ADR_A : ADR_B;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      wd_q      <= '0;
      arm_q     <= 1'b0;
      nl_q      <= 4'd0;
      cur_q     <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      i2c_rn_q  <= 1'b0;
      gemm_rn_q <= 1'b0;
      img_q     <= ADR_A;
      out_q     <= ADR_B;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      wd_q      <= wd_d;
      arm_q     <= arm_d;
      nl_q      <= nl_d;
      cur_q     <= cur_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      i2c_rn_q  <= i2c_rn_d;
      gemm_rn_q <= gemm_rn_d;
      img_q     <= img_d;
      out_q     <= out_d;
    end
  end

  assign bus.i2c_rst_n     = i2c_rn_q;
  assign bus.gemm_rst_n    = gemm_rn_q;
  assign bus.i2c_img_base  = img_q;
  assign bus.gemm_out_base = out_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = err_q;
  assign bus.cur_layer     = cur_q;
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: directed runs with timed expected output changes
// queued by the stimulus and matched by a monitor on every output change.
module tb_conv_layer_ctrl;
  localparam logic [31:0] A = 32'h0000_0000;
  localparam logic [31:0] B = 32'h0000_4000;

  typedef struct packed {
    logic        ir;
    logic        gr;
    logic [31:0] img;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  cur;
  } snap_t;

  typedef struct {
    int    stamp;
    snap_t s;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic fin = 1'b0;
  logic fin_done = 1'b0;
  ev_t  q[$];
  snap_t e;
  snap_t prev = '1;

  logic       i2c_man = 1'b0, i2c_val = 1'b0, i2c_mdl;
  logic       gemm_man = 1'b0, gemm_val = 1'b0, gemm_mdl;
  logic [7:0] i2c_cnt, gemm_cnt;

  conv_layer_ctrl_if #(.ADDR_WIDTH(32)) bus();

  conv_layer_ctrl #(
    .ADDR_WIDTH(32),
    .BUF_A(16'h0000),
    .BUF_B(16'h4000),
    .MAX_LAYERS(8),
    .RST_CYCLES(2),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine models: sticky done 10 cycles after reset release
  always @(posedge clk) begin
    if (!bus.i2c_rst_n) begin
      i2c_cnt <= 8'd0;
      i2c_mdl <= 1'b0;
    end else begin
      if (i2c_cnt == 8'd9) i2c_mdl <= 1'b1;
      if (i2c_cnt != 8'hff) i2c_cnt <= i2c_cnt + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (!bus.gemm_rst_n) begin
      gemm_cnt <= 8'd0;
      gemm_mdl <= 1'b0;
    end else begin
      if (gemm_cnt == 8'd9) gemm_mdl <= 1'b1;
      if (gemm_cnt != 8'hff) gemm_cnt <= gemm_cnt + 8'd1;
    end
  end

  assign bus.i2c_done  = i2c_man ? i2c_val : i2c_mdl;
  assign bus.gemm_done = gemm_man ? gemm_val : gemm_mdl;

  function automatic snap_t grab();
    snap_t s;
    s.ir   = bus.i2c_rst_n;
    s.gr   = bus.gemm_rst_n;
    s.img  = bus.i2c_img_base;
    s.out  = bus.gemm_out_base;
    s.busy = bus.busy;
    s.done = bus.done;
    s.err  = bus.error;
    s.cur  = bus.cur_layer;
    return s;
  endfunction

  always @(negedge clk) begin
    snap_t c;
    ev_t   v;
    c = grab();
    if (c != prev) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got ir=%b gr=%b img=%h out=%h busy=%b done=%b err=%b cur=%0d",
                 cyc, c.ir, c.gr, c.img, c.out, c.busy, c.done, c.err, c.cur);
      end else begin
        v = q.pop_front();
        if (v.stamp != cyc || v.s != c) begin
          failures++;
          $display("FAIL out_change got cyc=%0d ir=%b gr=%b img=%h out=%h busy=%b done=%b err=%b cur=%0d required cyc=%0d ir=%b gr=%b img=%h out=%h busy=%b done=%b err=%b cur=%0d",
                   cyc, c.ir, c.gr, c.img, c.out, c.busy, c.done, c.err, c.cur,
                   v.stamp, v.s.ir, v.s.gr, v.s.img, v.s.out, v.s.busy,
                   v.s.done, v.s.err, v.s.cur);
        end
      end
      prev = c;
    end
    if (fin && !fin_done) begin
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL missing_changes got pending=%0d required 0 next_cyc=%0d",
                 q.size(), q[0].stamp);
      end
      fin_done = 1'b1;
    end
  end

  task automatic put(input int t);
    ev_t v;
    v.stamp = t;
    v.s = e;
    q.push_back(v);
  endtask

  task automatic e_start();
    e.busy = 1'b1;
    e.done = 1'b0;
    e.err  = 1'b0;
    e.cur  = 4'd0;
    e.img  = A;
    e.out  = B;
  endtask

  task automatic exp_run(input int k, input int n);
    int s;
    e_start();
    put(k);
    s = k;
    for (int l = 0; l < n; l++) begin
      e.ir = 1'b1; put(s + 2);
      e.ir = 1'b0; put(s + 13);
      e.gr = 1'b1; put(s + 15);
      e.gr = 1'b0;
      if (l == n - 1) begin
        e.busy = 1'b0;
        e.done = 1'b1;
      end else begin
        e.cur = 4'(l + 1);
        e.img = ((l + 1) % 2 == 1) ? B : A;
        e.out = ((l + 1) % 2 == 1) ? A : B;
      end
      put(s + 26);
      s = s + 26;
    end
  endtask

  task automatic pulse(input logic st, input logic [3:0] n, input logic ab);
    bus.start = st;
    bus.num_layers = n;
    bus.abort = ab;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int k;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_layers = 4'd0;
    e.ir = 1'b0; e.gr = 1'b0; e.img = A; e.out = B;
    e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.cur = 4'd0;
    put(1);
    wait_to(3);
    rst_n = 1'b1;

    // single layer
    k = cyc + 1; exp_run(k, 1); pulse(1'b1, 4'd1, 1'b0); wait_to(k + 28);

    // three layers, with a start during busy that must be ignored
    k = cyc + 1; exp_run(k, 3); pulse(1'b1, 4'd3, 1'b0);
    wait_to(k + 30); pulse(1'b1, 4'd1, 1'b0); wait_to(k + 80);

    // stale im2col done
    i2c_man = 1'b1; i2c_val = 1'b1;
    k = cyc + 1; e_start(); put(k);
    e.ir = 1'b1; put(k + 2);
    e.ir = 1'b0; put(k + 9);
    e.gr = 1'b1; put(k + 11);
    e.gr = 1'b0; e.busy = 1'b0; e.done = 1'b1; put(k + 22);
    pulse(1'b1, 4'd1, 1'b0);
    wait_to(k + 7); i2c_val = 1'b0;
    wait_to(k + 8); i2c_val = 1'b1;
    wait_to(k + 24); i2c_man = 1'b0;

    // GEMM timeout, then recovery from ERR
    gemm_man = 1'b1; gemm_val = 1'b0;
    k = cyc + 1; e_start(); put(k);
    e.ir = 1'b1; put(k + 2);
    e.ir = 1'b0; put(k + 13);
    e.gr = 1'b1; put(k + 15);
    e.gr = 1'b0; e.busy = 1'b0; e.err = 1'b1; put(k + 79);
    pulse(1'b1, 4'd1, 1'b0); wait_to(k + 81); gemm_man = 1'b0;
    k = cyc + 1; exp_run(k, 1); pulse(1'b1, 4'd1, 1'b0); wait_to(k + 28);

    // illegal counts and abort in IDLE
    k = cyc + 1; e.done = 1'b0; e.err = 1'b1; put(k);
    pulse(1'b1, 4'd0, 1'b0); wait_to(k + 2);
    k = cyc + 1; e.err = 1'b0; put(k);
    pulse(1'b0, 4'd0, 1'b1); wait_to(k + 2);
    k = cyc + 1; e.err = 1'b1; put(k);
    pulse(1'b1, 4'd9, 1'b0); wait_to(k + 2);
    k = cyc + 1; e.err = 1'b0; put(k);
    pulse(1'b1, 4'd1, 1'b1); wait_to(k + 30);

    // abort in cycle 4 of I2C_WAIT
    k = cyc + 1; e_start(); put(k);
    e.ir = 1'b1; put(k + 2);
    e.ir = 1'b0; e.busy = 1'b0; put(k + 6);
    pulse(1'b1, 4'd1, 1'b0); wait_to(k + 5);
    pulse(1'b0, 4'd0, 1'b1); wait_to(k + 20);

    // abort in the same cycle as the final GEMM completion
    k = cyc + 1; e_start(); put(k);
    e.ir = 1'b1; put(k + 2);
    e.ir = 1'b0; put(k + 13);
    e.gr = 1'b1; put(k + 15);
    e.gr = 1'b0; e.busy = 1'b0; put(k + 26);
    pulse(1'b1, 4'd1, 1'b0); wait_to(k + 25);
    pulse(1'b0, 4'd0, 1'b1); wait_to(k + 30);

    // MAX_LAYERS run, then abort in IDLE clears done
    k = cyc + 1; exp_run(k, 8); pulse(1'b1, 4'd8, 1'b0);
    wait_to(k + 26 * 8 + 2);
    k = cyc + 1; e.done = 1'b0; put(k);
    pulse(1'b0, 4'd0, 1'b1); wait_to(k + 2);

    // rst_n mid-sequence in layer 1
    k = cyc + 1; e_start(); put(k);
    e.ir = 1'b1; put(k + 2);
    e.ir = 1'b0; put(k + 13);
    e.gr = 1'b1; put(k + 15);
    e.gr = 1'b0; e.cur = 4'd1; e.img = B; e.out = A; put(k + 26);
    e.ir = 1'b1; put(k + 28);
    e.ir = 1'b0; e.busy = 1'b0; e.cur = 4'd0; e.img = A; e.out = B;
    put(k + 30);
    pulse(1'b1, 4'd2, 1'b0); wait_to(k + 29);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    wait_to(k + 40);

    fin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
